// File: rtl/ldl_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// ldl_dispatch_pkg : shared helpers for the credit-based priority dispatcher
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ldl_dispatch_pkg;

  // Widest one-hot vector the index helper can encode, and its index width
  localparam int unsigned OH_MAX = 64;
  localparam int unsigned IDX_W  = 6;

  function automatic int unsigned crd_max_f(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic logic [IDX_W-1:0] onehot2bin(input logic [OH_MAX-1:0] oh);
    logic [IDX_W-1:0] b;
    b = '0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) b = b | IDX_W'(i);
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ldl_rr_pick.sv
// ----------------------------------------------------------------------------
// ldl_rr_pick : combinational masked round-robin pick, search starts at last+1
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ldl_rr_pick
  import ldl_dispatch_pkg::*;
#(
  parameter int BIN_WIDTH = 3,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic [REQ_WIDTH-1:0] cand,
  input  logic [BIN_WIDTH-1:0] last,
  output logic [REQ_WIDTH-1:0] pick_oh,
  output logic [BIN_WIDTH-1:0] pick_bin
);

  logic [REQ_WIDTH-1:0] masked;

  always_comb begin
    logic found;
    found = 1'b0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      masked[i] = cand[i] && (i > int'(last));
    end
    pick_oh = '0;
    // Upper half first; wrap to the lowest candidate when nothing lies above last
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (!found && masked[i]) begin
        pick_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (!found && cand[i]) begin
        pick_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign pick_bin = BIN_WIDTH'(onehot2bin(OH_MAX'(pick_oh)));

endmodule

`default_nettype wire

// File: rtl/ldl_dispatch_pri.sv
// ----------------------------------------------------------------------------
// ldl_dispatch_pri : 1-to-N dispatcher, most-credits-first with round-robin ties
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ldl_dispatch_pri
  import ldl_dispatch_pkg::*;
#(
  parameter int BIN_WIDTH  = 3,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int CRD_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [REQ_WIDTH-1:0]  crd_ret,
  output logic [REQ_WIDTH-1:0]  out_valid,
  output logic [BIN_WIDTH-1:0]  out_bin,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  err
);

  localparam logic [CRD_WIDTH-1:0] CRD_MAX = CRD_WIDTH'(crd_max_f(CRD_WIDTH));
  localparam logic [CRD_WIDTH-1:0] CRD_ONE = CRD_WIDTH'(1);

  typedef struct packed {
    logic [REQ_WIDTH-1:0]  valid;
    logic [BIN_WIDTH-1:0]  bin;
    logic [DATA_WIDTH-1:0] data;
  } disp_out_t;

  logic [CRD_WIDTH-1:0] crd [REQ_WIDTH];
  logic [BIN_WIDTH-1:0] last;
  logic [CRD_WIDTH-1:0] max_crd;
  logic [REQ_WIDTH-1:0] eligible;
  logic [REQ_WIDTH-1:0] cand;
  logic [REQ_WIDTH-1:0] at_max;
  logic [REQ_WIDTH-1:0] pick_oh;
  logic [REQ_WIDTH-1:0] dispatched;
  logic [BIN_WIDTH-1:0] pick_bin;
  logic                 fire;
  disp_out_t            out_q;

  // Empty workers hold zero, so the plain maximum already excludes them
  always_comb begin
    max_crd = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (crd[i] > max_crd) max_crd = crd[i];
    end
  end

  for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_flags
    assign eligible[g] = (crd[g] != '0);
    assign cand[g]     = eligible[g] && (crd[g] == max_crd);
    assign at_max[g]   = (crd[g] == CRD_MAX);
  end

  assign in_ready   = |eligible;
  assign fire       = in_valid && in_ready;
  assign dispatched = fire ? pick_oh : '0;

  ldl_rr_pick #(
    .BIN_WIDTH (BIN_WIDTH),
    .REQ_WIDTH (REQ_WIDTH)
  ) u_pick (
    .cand     (cand),
    .last     (last),
    .pick_oh  (pick_oh),
    .pick_bin (pick_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQ_WIDTH; i++) crd[i] <= CRD_MAX;
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        if (dispatched[i] && !crd_ret[i])
          crd[i] <= crd[i] - CRD_ONE;
        else if (!dispatched[i] && crd_ret[i] && !at_max[i])
          crd[i] <= crd[i] + CRD_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      last  <= BIN_WIDTH'(REQ_WIDTH - 1);
      err   <= 1'b0;
    end else begin
      out_q.valid <= dispatched;
      if (fire) begin
        out_q.bin  <= pick_bin;
        out_q.data <= in_data;
        last       <= pick_bin;
      end
      // A return that coincides with a dispatch to the same worker is legal
      if (|(crd_ret & ~dispatched & at_max)) err <= 1'b1;
    end
  end

  assign out_valid = out_q.valid;
  assign out_bin   = out_q.bin;
  assign out_data  = out_q.data;

endmodule

`default_nettype wire

// File: tb/tb_ldl_dispatch_pri.sv
// ----------------------------------------------------------------------------
// tb_ldl_dispatch_pri : directed self-checking bench for ldl_dispatch_pri
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ldl_dispatch_pri;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] crd_ret;
  logic [7:0] out_valid;
  logic [2:0] out_bin;
  logic [7:0] out_data;
  logic       err;

  int checks = 0;
  int errors = 0;

  ldl_dispatch_pri #(
    .BIN_WIDTH  (3),
    .REQ_WIDTH  (8),
    .DATA_WIDTH (8),
    .CRD_WIDTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .crd_ret   (crd_ret),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_data  (out_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_crd(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_crd%0d", tag, i), 32'(dut.crd[i]), 32'(exp));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    crd_ret  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_bin",   32'(out_bin),   32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_err",       32'(err),       32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);

    // 24 back-to-back items: three passes over workers 0..7, draining every credit
    for (int k = 0; k < 24; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + k);
      tick();
      check($sformatf("strm%0d_valid", k), 32'(out_valid), 32'(8'h01 << (k % 8)));
      check($sformatf("strm%0d_bin", k),   32'(out_bin),   32'(k % 8));
      check($sformatf("strm%0d_data", k),  32'(out_data),  32'(8'h10 + k));
      if (k == 7) check_all_crd("pass1", 2'd2);
    end
    check("empty_in_ready", 32'(in_ready), 32'h0);
    check_all_crd("empty", 2'd0);
    for (int k = 0; k < 2; k++) begin
      in_data = 8'hEE;
      tick();
      check($sformatf("empty%0d_valid", k), 32'(out_valid), 32'h0);
      check($sformatf("empty%0d_data", k),  32'(out_data),  32'h27);
    end

    // Single return to worker 5 wakes the dispatcher
    crd_ret = 8'h20;
    tick();
    crd_ret = 8'h00;
    check("ret5_in_ready",  32'(in_ready),  32'h1);
    check("ret5_out_valid", 32'(out_valid), 32'h0);
    in_data = 8'hA5;
    tick();
    check("w5_valid",    32'(out_valid), 32'h20);
    check("w5_bin",      32'(out_bin),   32'h5);
    check("w5_data",     32'(out_data),  32'hA5);
    check("w5_in_ready", 32'(in_ready),  32'h0);
    in_valid = 1'b0;

    // Build crd = {3,1,1,1,1,1,1,1} with worker 0 at 3
    crd_ret = 8'hFF;
    tick();
    crd_ret = 8'h01;
    tick();
    tick();
    check("pri_crd0", 32'(dut.crd[0]), 32'h3);
    check("pri_crd7", 32'(dut.crd[7]), 32'h1);
    // Dispatch to 0 with a simultaneous return: credit stays at 3, last becomes 0
    in_valid = 1'b1;
    in_data  = 8'hB0;
    tick();
    crd_ret = 8'h00;
    check("pri1_bin",  32'(out_bin),      32'h0);
    check("pri1_crd0", 32'(dut.crd[0]),   32'h3);
    check("pri1_err",  32'(err),          32'h0);
    in_data = 8'hB1;
    tick();
    check("pri2_valid", 32'(out_valid),   32'h01);
    check("pri2_bin",   32'(out_bin),     32'h0);
    check("pri2_data",  32'(out_data),    32'hB1);
    check("pri2_crd0",  32'(dut.crd[0]),  32'h2);

    // Reset during streaming
    in_data = 8'h60;
    tick();
    check("pre_rst_bin", 32'(out_bin), 32'h0);
    rst     = 1'b1;
    in_data = 8'h61;
    tick();
    rst = 1'b0;
    check("mid_rst_valid",    32'(out_valid), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready),  32'h1);
    check("mid_rst_err",      32'(err),       32'h0);
    check_all_crd("mid_rst", 2'd3);
    in_data = 8'h77;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'h01);
    check("post_rst_bin",   32'(out_bin),   32'h0);
    check("post_rst_data",  32'(out_data),  32'h77);
    in_data = 8'h78;
    tick();
    check("post_rst2_bin", 32'(out_bin), 32'h1);

    // Same-cycle dispatch and return on worker 2
    in_data = 8'h79;
    crd_ret = 8'h04;
    tick();
    crd_ret  = 8'h00;
    in_valid = 1'b0;
    check("same2_valid", 32'(out_valid),  32'h04);
    check("same2_bin",   32'(out_bin),    32'h2);
    check("same2_crd2",  32'(dut.crd[2]), 32'h3);
    check("same2_err",   32'(err),        32'h0);

    // Over-return to worker 4 (already full) is sticky
    crd_ret = 8'h10;
    tick();
    crd_ret = 8'h00;
    check("over4_err",  32'(err),        32'h1);
    check("over4_crd4", 32'(dut.crd[4]), 32'h3);
    check("idle_valid", 32'(out_valid),  32'h0);
    check("idle_bin",   32'(out_bin),    32'h2);
    tick();
    tick();
    check("sticky_err", 32'(err), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("clr_err", 32'(err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ldl_dispatch_pri.md
# ldl_dispatch_pri

Credit-based round-robin dispatcher with priority: the 1-to-N counterpart of the library's N-to-1 priority arbiter. One producer stream is fanned out to `REQ_WIDTH` workers. Each worker advertises free capacity through returned credits. Every accepted item goes to the worker holding the most credits; ties are broken round robin. Sits between a single work source and a bank of identical processing engines.

## Interface
- `BIN_WIDTH`, 3, log2 of worker count
- `REQ_WIDTH`, `1 << BIN_WIDTH`, number of workers
- `DATA_WIDTH`, 8, payload width
- `CRD_WIDTH`, 2, credit counter width; `CRD_MAX = (1<<CRD_WIDTH)-1` credits per worker
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `in_valid`  in  1  producer has an item
- `in_data`  in  `DATA_WIDTH`  producer payload
- `in_ready`  out  1  dispatcher can accept; transfer when `in_valid && in_ready`
- `crd_ret`  in  `REQ_WIDTH`  per-worker one-cycle credit return pulses, any combination per cycle
- `out_valid`  out  `REQ_WIDTH`  one-hot dispatch strobe, registered
- `out_bin`  out  `BIN_WIDTH`  binary index of the strobed worker, registered
- `out_data`  out  `DATA_WIDTH`  payload shared by all workers, registered
- `err`  out  1  sticky: credit returned to a worker already at `CRD_MAX`

## Operation
- Per worker i: credit counter `crd[i]`, reset to `CRD_MAX`.
- Eligible set: `crd[i] != 0`. `in_ready = |eligible`, driven combinationally from registers only; it never depends on `in_valid`.
- Class selection: `max_crd` = largest `crd[i]` over the eligible set. Candidates are the eligible workers with `crd[i] == max_crd`.
- Tie-break: round-robin pick among candidates, starting at `(last + 1) mod REQ_WIDTH`. `last` is the index of the previous dispatch; reset value `REQ_WIDTH-1`, so worker 0 wins first.
- On transfer: `out_valid` gets the one-hot pick, `out_bin` its index, `out_data = in_data`, `last = pick`, and `crd[pick]` is decremented.
- No transfer in a cycle: `out_valid` drops to 0 on the next edge. `out_data` and `out_bin` hold their last values.
- Credit update per worker per cycle: dispatched and returned together gives no change; dispatched only gives -1; returned only gives +1, saturating at `CRD_MAX`.
- Returning a credit when `crd[i] == CRD_MAX` and the worker is not dispatched that cycle sets `err`. `err` is cleared only by `rst`.
- A return arriving in the same cycle as a selection does not affect that selection; the selection uses the pre-edge counter values.

## Timing
- Latency: an item accepted at edge k appears on `out_*` at edge k+1, with `out_valid` high for exactly one cycle.
- Throughput: one item per cycle while any credit exists.
- Empty (all `crd == 0`): `in_ready` is 0. A return at edge k makes `in_ready` 1 after edge k, and a transfer is possible at edge k+1.
- Reset values: `out_valid = 0`, `out_bin = 0`, `out_data = 0`, `err = 0`, all `crd = CRD_MAX`, `last = REQ_WIDTH-1`, so `in_ready = 1` after reset.
- Reset mid-operation: in-flight strobes are dropped and all credits are restored. The producer and workers are reset together.
- `in_valid` low with `in_ready` high: no state change except credit returns.

## Structure
- Package `ldl_dispatch_pkg`:
  - `CRD_MAX` function of `CRD_WIDTH`
  - `onehot2bin` function
  - parameterised struct for `{out_valid, out_bin, out_data}`
- Sub-module `ldl_rr_pick`: pure combinational masked round-robin pick. Inputs `cand[REQ_WIDTH]` and `last`; outputs one-hot and binary index. The top level holds the counters, max-class reduction, output registers and `err`.
- Expected size: about 200 lines total.

## Test plan
- Reset, then `in_valid` held for 8 cycles, N=8, `CRD_MAX=3`, no returns -> workers 0..7 strobed once each in order, `out_data` matches input with 1-cycle lag, all `crd = 2`.
- Continue holding `in_valid` with no returns -> 16 more dispatches cycling 0..7 twice. `in_ready` then goes 0 with all `crd = 0`, and further `in_valid` is ignored.
- From all-zero, return one credit to worker 5 -> `in_ready` 1 the next cycle, and the next item goes to worker 5.
- Priority: from `crd = {3,1,1,1,1,1,1,1}` (worker 0 at 3) with `last = 0` -> next dispatch goes to worker 0 despite the rotation.
- Same-cycle dispatch and return on worker 2 -> `crd[2]` unchanged, `err` stays 0. A return to worker 4 while `crd[4] = 3` -> `err` 1 and stays high until `rst`.
- Assert `rst` for one cycle during streaming -> the next cycle shows `out_valid = 0`, all credits at 3, and the next dispatch goes to worker 0.
